shift_arbiter: RTL and testbench
================================

Name: shift_arbiter

Overview:
- Shares one combinational right shifter (srl/sra) between two requesters, req0 and req1, using a round-robin grant.
- Synthesises sll by bit-reversing the operand before the shifter and bit-reversing the shifter output after it.
- Registers the result in a single output slot with a valid/ready handshake.
- Sits in the execute stage between the ALU-issue path (req0) and the address/CSR helper path (req1) and the shared shift resource.

Parameters:
- T, 0.000, propagation delay passed unchanged to the shifter instance.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  2  requester 0 op: 00 sll, 01 srl, 11 sra, 10 reserved (executes as srl).
- req0_data  in  32  requester 0 operand.
- req0_shamt  in  5  requester 0 shift amount.
- req1_valid, req1_ready, req1_op, req1_data, req1_shamt: same widths and meaning for requester 1.
- rsp_valid  out  1  result slot full.
- rsp_ready  in  1  consumer takes the result this cycle.
- rsp_data  out  32  shifted result.
- rsp_id  out  1  requester that produced rsp_data (0 or 1).

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, last_grant=1 (so req0 wins the first contention). req0_ready and req1_ready are 0 during any cycle with rst=1.
- Accept condition: can_accept = !rsp_valid | rsp_ready. Draining and refilling the slot in the same cycle is allowed, giving full throughput of one op per cycle.
- Grant rules:
  - Only req0 valid -> grant 0.
  - Only req1 valid -> grant 1.
  - Both valid -> grant the requester other than last_grant.
- reqN_ready = can_accept & reqN_valid & (grant==N). reqN_ready never depends on rsp_data. It may depend combinationally on rsp_ready and on both valids.
- On a transfer (reqN_valid & reqN_ready), at the same clock edge:
  - rsp_data <= shift result of the granted inputs.
  - rsp_id <= N.
  - rsp_valid <= 1.
  - last_grant <= N.
- If the slot drains (rsp_ready=1) with no transfer: rsp_valid <= 0; rsp_data and rsp_id hold their values.
- Latency: exactly 1 cycle from accept to rsp_valid.
- While rsp_valid=1 and rsp_ready=0: rsp_data and rsp_id hold stable, and both readies are 0.
- Datapath rules:
  - mode = op[1] & op[0] (sra only for 11).
  - rev = (op==00).
  - Shifter input = rev ? bitreverse(data) : data.
  - Result = rev ? bitreverse(shifter_out) : shifter_out.
- shamt=0 -> result = data for all ops.
- shamt=31, sra -> all bits = data[31].
- Requesters must hold valid and payload until ready. A dropped valid is simply not granted, and last_grant is unchanged.
- Reset asserted mid-transfer discards the held result; no response is produced for that operation.
- No combinational path from rsp_ready to rsp_data.

Decomposition:
- Shared package holds the op encodings SHIFT_OP_SLL=2'b00, SHIFT_OP_SRL=2'b01, SHIFT_OP_SRA=2'b11, SHIFT_OP_RSV=2'b10, and the 32-bit width constant.
- Sub-module: the existing shift_right32 instantiated once (parameter T forwarded).
- Bit reversal and the round-robin pointer stay inline.

Test Plan:
- Reset, then req0 only, srl, data 0x8000_0000, shamt 4 -> req0_ready=1; next cycle rsp_valid=1, rsp_data 0x0800_0000, rsp_id=0.
- req1 only, sra, data 0x8000_00F0, shamt 4 -> rsp_data 0xF800_000F, rsp_id=1. Same request with sll and shamt 31 on 0x0000_0001 -> rsp_data 0x8000_0000.
- Both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0 after reset; one result per cycle; rsp_id follows the same order.
- rsp_ready=0 for 3 cycles with the slot full, both valid -> both readies 0, rsp_data stable. At rsp_ready=1, accept and drain occur in the same cycle, with no bubble.
- Corner operands with shamt=0 (ops 00/01/11/10, data 0xDEAD_BEEF) return 0xDEAD_BEEF. Op 10 with data 0x8000_0000, shamt 1 -> 0x4000_0000 (executes as srl).
- rst asserted while rsp_valid=1 -> next cycle rsp_valid=0, rsp_data=0. The first contention after reset grants req0.

Source files
------------

// File: rtl/shift_arbiter_pkg.sv
// Shared constants for the shift arbiter: op encodings and datapath width.
package shift_arbiter_pkg;

  localparam int unsigned SHIFT_WIDTH = 32;

  localparam logic [1:0] SHIFT_OP_SLL = 2'b00;
  localparam logic [1:0] SHIFT_OP_SRL = 2'b01;
  localparam logic [1:0] SHIFT_OP_SRA = 2'b11;
  localparam logic [1:0] SHIFT_OP_RSV = 2'b10;

endpackage

// File: rtl/shift_arbiter_if.sv
// Two requester ports and one response slot of the shared shifter.
interface shift_arbiter_if;
  import shift_arbiter_pkg::*;

  logic                   req0_valid;
  logic                   req0_ready;
  logic [1:0]             req0_op;
  logic [SHIFT_WIDTH-1:0] req0_data;
  logic [4:0]             req0_shamt;

  logic                   req1_valid;
  logic                   req1_ready;
  logic [1:0]             req1_op;
  logic [SHIFT_WIDTH-1:0] req1_data;
  logic [4:0]             req1_shamt;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [SHIFT_WIDTH-1:0] rsp_data;
  logic                   rsp_id;

  modport master (
    output req0_valid, req0_op, req0_data, req0_shamt,
    output req1_valid, req1_op, req1_data, req1_shamt,
    output rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req0_valid, req0_op, req0_data, req0_shamt,
    input  req1_valid, req1_op, req1_data, req1_shamt,
    input  rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/shift_right32.sv
// Combinational 32-bit right shifter, logical or arithmetic.
module shift_right32 #(
  parameter real T = 0.000
) (
  input  logic [31:0] data_i,
  input  logic [4:0]  shamt_i,
  input  logic        arith_i,
  output logic [31:0] result_o
);

  // T is a modelling delay only; a negative value is a configuration error.
  if (T < 0.0) begin : g_bad_delay
    $error("shift_right32: negative delay T");
  end

  assign result_o = arith_i ? 32'($signed(data_i) >>> shamt_i) : (data_i >> shamt_i);

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin sharing of one right shifter between two requesters; sll is
// done by bit-reversing around the shifter. One registered result slot.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter real T = 0.000
) (
  input  logic            clk,
  input  logic            rst,
  shift_arbiter_if.slave  bus
);

  logic                   rsp_valid_q, rsp_valid_d;
  logic [SHIFT_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                   rsp_id_q, rsp_id_d;
  logic                   last_grant_q, last_grant_d;

  logic                   can_accept;
  logic                   grant;
  logic                   fire;
  logic [1:0]             sel_op;
  logic [SHIFT_WIDTH-1:0] sel_data;
  logic [4:0]             sel_shamt;
  logic                   rev;
  logic                   mode;
  logic [SHIFT_WIDTH-1:0] shift_in;
  logic [SHIFT_WIDTH-1:0] shift_out;
  logic [SHIFT_WIDTH-1:0] result;

  assign can_accept = ~rsp_valid_q | bus.rsp_ready;

  // Under contention the requester that did not win last time goes first.
  assign grant = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;

  assign bus.req0_ready = ~rst & can_accept & bus.req0_valid & ~grant;
  assign bus.req1_ready = ~rst & can_accept & bus.req1_valid & grant;
  assign fire           = bus.req0_ready | bus.req1_ready;

  assign sel_op    = grant ? bus.req1_op    : bus.req0_op;
  assign sel_data  = grant ? bus.req1_data  : bus.req0_data;
  assign sel_shamt = grant ? bus.req1_shamt : bus.req0_shamt;

  assign mode     = sel_op[1] & sel_op[0];
  assign rev      = (sel_op == SHIFT_OP_SLL);
  assign shift_in = rev ? {<<{sel_data}} : sel_data;
  assign result   = rev ? {<<{shift_out}} : shift_out;

  shift_right32 #(
    .T (T)
  ) u_shift (
    .data_i   (shift_in),
    .shamt_i  (sel_shamt),
    .arith_i  (mode),
    .result_o (shift_out)
  );

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    if (fire) begin
      rsp_valid_d  = 1'b1;
      rsp_data_d   = result;
      rsp_id_d     = grant;
      last_grant_d = grant;
    end else if (bus.rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: stimulus pushes expected results into a
// scoreboard queue, a forked monitor checks every presented response.
module tb_shift_arbiter;
  import shift_arbiter_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        id;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_arbiter_if bus();

  shift_arbiter #(
    .T (0.000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; called just after a rising edge.
  task automatic drive(input string name,
                       input logic v0, input logic [1:0] o0, input logic [31:0] d0,
                       input logic [4:0] s0,
                       input logic v1, input logic [1:0] o1, input logic [31:0] d1,
                       input logic [4:0] s1,
                       input logic rr, input logic er0, input logic er1,
                       input logic [31:0] ed);
    bus.req0_valid = v0; bus.req0_op = o0; bus.req0_data = d0; bus.req0_shamt = s0;
    bus.req1_valid = v1; bus.req1_op = o1; bus.req1_data = d1; bus.req1_shamt = s1;
    bus.rsp_ready  = rr;
    @(negedge clk);
    chk({name, " req0_ready"}, 32'(bus.req0_ready), 32'(er0));
    chk({name, " req1_ready"}, 32'(bus.req1_ready), 32'(er1));
    if (er0 | er1) sb.push_back('{ed, er1});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_op = SHIFT_OP_SRL; bus.req0_data = 32'h1; bus.req0_shamt = 5'd0;
    bus.req1_valid = 1'b1; bus.req1_op = SHIFT_OP_SRL; bus.req1_data = 32'h2; bus.req1_shamt = 5'd0;
    bus.rsp_ready  = 1'b0;
    sb.delete();
    @(negedge clk);
    chk({name, " req0_ready in rst"}, 32'(bus.req0_ready), 32'd0);
    chk({name, " req1_ready in rst"}, 32'(bus.req1_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({name, " rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({name, " rsp_data"}, bus.rsp_data, 32'd0);
    chk({name, " rsp_id"}, 32'(bus.rsp_id), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!rst && bus.rsp_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got %08h id %0d want none", bus.rsp_data, bus.rsp_id);
          end else begin
            chk("rsp_data", bus.rsp_data, sb[0].data);
            chk("rsp_id", 32'(bus.rsp_id), 32'(sb[0].id));
            if (bus.rsp_ready) void'(sb.pop_front());
          end
        end
      end
    join_none

    do_reset("reset0");

    // Single requesters.
    drive("srl r0", 1, SHIFT_OP_SRL, 32'h8000_0000, 5'd4, 0, SHIFT_OP_SRL, 32'h0, 5'd0,
          1, 1, 0, 32'h0800_0000);
    drive("sra r1", 0, SHIFT_OP_SRL, 32'h0, 5'd0, 1, SHIFT_OP_SRA, 32'h8000_00F0, 5'd4,
          1, 0, 1, 32'hF800_000F);
    drive("sll r1", 0, SHIFT_OP_SRL, 32'h0, 5'd0, 1, SHIFT_OP_SLL, 32'h0000_0001, 5'd31,
          1, 0, 1, 32'h8000_0000);

    // Contention: grants alternate 0,1,0,1; losers hold their payload.
    drive("rr c1", 1, SHIFT_OP_SRL, 32'h0000_00F0, 5'd4, 1, SHIFT_OP_SLL, 32'h1, 5'd1,
          1, 1, 0, 32'h0000_000F);
    drive("rr c2", 1, SHIFT_OP_SRA, 32'hF000_0000, 5'd8, 1, SHIFT_OP_SLL, 32'h1, 5'd1,
          1, 0, 1, 32'h0000_0002);
    drive("rr c3", 1, SHIFT_OP_SRA, 32'hF000_0000, 5'd8, 1, SHIFT_OP_SRL, 32'hFFFF_FFFF, 5'd31,
          1, 1, 0, 32'hFFF0_0000);
    drive("rr c4", 1, SHIFT_OP_SLL, 32'h1234_5678, 5'd4, 1, SHIFT_OP_SRL, 32'hFFFF_FFFF, 5'd31,
          1, 0, 1, 32'h0000_0001);

    // Back-pressure: slot full, no accepts; then drain and refill together.
    for (int i = 0; i < 3; i++) begin
      drive("stall", 1, SHIFT_OP_SLL, 32'h1234_5678, 5'd4, 1, SHIFT_OP_SRA, 32'h8000_0000, 5'd31,
            0, 0, 0, 32'h0);
    end
    drive("refill", 1, SHIFT_OP_SLL, 32'h1234_5678, 5'd4, 1, SHIFT_OP_SRA, 32'h8000_0000, 5'd31,
          1, 1, 0, 32'h2345_6780);
    drive("after stall", 0, SHIFT_OP_SRL, 32'h0, 5'd0, 1, SHIFT_OP_SRA, 32'h8000_0000, 5'd31,
          1, 0, 1, 32'hFFFF_FFFF);

    // Zero shift returns the operand for every op; reserved op acts as srl.
    drive("sh0 sll", 1, SHIFT_OP_SLL, 32'hDEAD_BEEF, 5'd0, 0, SHIFT_OP_SRL, 32'h0, 5'd0,
          1, 1, 0, 32'hDEAD_BEEF);
    drive("sh0 srl", 1, SHIFT_OP_SRL, 32'hDEAD_BEEF, 5'd0, 0, SHIFT_OP_SRL, 32'h0, 5'd0,
          1, 1, 0, 32'hDEAD_BEEF);
    drive("sh0 sra", 1, SHIFT_OP_SRA, 32'hDEAD_BEEF, 5'd0, 0, SHIFT_OP_SRL, 32'h0, 5'd0,
          1, 1, 0, 32'hDEAD_BEEF);
    drive("sh0 rsv", 1, SHIFT_OP_RSV, 32'hDEAD_BEEF, 5'd0, 0, SHIFT_OP_SRL, 32'h0, 5'd0,
          1, 1, 0, 32'hDEAD_BEEF);
    drive("rsv srl", 1, SHIFT_OP_RSV, 32'h8000_0000, 5'd1, 0, SHIFT_OP_SRL, 32'h0, 5'd0,
          1, 1, 0, 32'h4000_0000);

    // Idle cycle leaves last_grant at 0, so the next contention goes to req1.
    drive("idle", 0, SHIFT_OP_SRL, 32'h0, 5'd0, 0, SHIFT_OP_SRL, 32'h0, 5'd0,
          1, 0, 0, 32'h0);
    drive("rr keep", 1, SHIFT_OP_SRL, 32'h0000_0010, 5'd4, 1, SHIFT_OP_SRL, 32'h0000_0100, 5'd8,
          1, 0, 1, 32'h0000_0001);

    // Reset with a result in flight discards it; first contention then goes to req0.
    drive("pre rst", 1, SHIFT_OP_SRL, 32'hAAAA_0000, 5'd16, 0, SHIFT_OP_SRL, 32'h0, 5'd0,
          1, 1, 0, 32'h0000_AAAA);
    do_reset("reset1");
    drive("post rst", 1, SHIFT_OP_SRL, 32'h0000_00F0, 5'd4, 1, SHIFT_OP_SRA, 32'h8000_0000, 5'd1,
          1, 1, 0, 32'h0000_000F);

    for (int i = 0; i < 2; i++) begin
      drive("drain", 0, SHIFT_OP_SRL, 32'h0, 5'd0, 0, SHIFT_OP_SRL, 32'h0, 5'd0,
            1, 0, 0, 32'h0);
    end
    chk("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
